timer_dev: RTL and testbench

TIMER_DEV -- requirements
Module: timer_dev

---
 rtl/timer_dev_pkg.sv | 34 +++
 rtl/timer_dev.sv | 120 ++++++++++++
 tb/tb_timer_dev.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_pkg.sv
// Shared CPU-side constants for the timer: FSM encodings, register offsets,
// CTRL bit positions, and a helper that builds the CTRL read-back word.
package timer_dev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  // Only 01 reloads; 00, 10 and 11 all run once.
  localparam logic [1:0] MODE_AUTO = 2'b01;

  function automatic logic [31:0] pack_ctrl(input logic       en,
                                            input logic [1:0] mode,
                                            input logic       im);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT]           = en;
    w[CTRL_MODE_LSB +: 2]    = mode;
    w[CTRL_IM_BIT]           = im;
    return w;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped down-counter timer: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload operation, interrupt flag masked by IM onto IRQ.
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  timer_state_e r_state;
  timer_state_e w_state_nxt;

  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;
  logic        r_irq_auto;

  logic [31:0] w_count_nxt;
  logic        w_int_set;
  logic        w_int_clr_en;
  logic        w_wr_ctrl;
  logic        w_wr_preset;

  assign w_wr_ctrl   = WE && (Addr == OFS_CTRL);
  assign w_wr_preset = WE && (Addr == OFS_PRESET);

  // A zero PRESET skips CNT and goes straight to INT, so the interrupt
  // arrives three edges after Enable is written.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_int_set    = 1'b0;
    w_int_clr_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_en) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = (r_preset == 32'd0) ? ST_INT : ST_CNT;
      end
      ST_CNT: begin
        if (!r_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          w_count_nxt = 32'd0;
          w_state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        w_int_set = 1'b1;
        if (r_mode == MODE_AUTO) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_int_clr_en = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_en       <= 1'b0;
      r_mode     <= 2'b00;
      r_im       <= 1'b0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
      r_irq_auto <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;

      // A CPU write to CTRL overrides the one-shot Enable clear.
      if (w_wr_ctrl) begin
        r_en   <= Din[CTRL_EN_BIT];
        r_mode <= Din[CTRL_MODE_LSB +: 2];
        r_im   <= Din[CTRL_IM_BIT];
      end else if (w_int_clr_en) begin
        r_en <= 1'b0;
      end

      if (w_wr_preset) r_preset <= Din;

      // Setting wins over both clear sources; auto-reload flags live one cycle.
      r_irq_auto <= w_int_set && (r_mode == MODE_AUTO);
      if (w_int_set) begin
        r_irq_flag <= 1'b1;
      end else if (w_wr_ctrl || r_irq_auto) begin
        r_irq_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      OFS_CTRL:   Dout = pack_ctrl(r_en, r_mode, r_im);
      OFS_PRESET: Dout = r_preset;
      OFS_COUNT:  Dout = r_count;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = r_irq_flag & r_im;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus randomized
// PRESET/mode/IM runs compared against a closed-form timing model.
module tb_timer_dev;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_checks = 0;
  int n_pass   = 0;

  timer_dev dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Model: t counts edges after the Enable write. First load lands at t=2,
  // loads repeat every per = (P==0 ? 2 : P+2) edges in auto-reload, and the
  // flag appears on the last edge of each period.
  function automatic logic [31:0] model_count(int p, bit auto_rl, int t);
    int per;
    int u;
    if (t < 2) return 32'd0;
    per = (p == 0) ? 2 : p + 2;
    u   = auto_rl ? (t - 2) % per : (t - 2);
    return (u >= p) ? 32'd0 : 32'(p - u);
  endfunction

  function automatic logic model_irq(int p, bit auto_rl, bit im, int t);
    int per;
    bit flag;
    if (t < 2) return 1'b0;
    per = (p == 0) ? 2 : p + 2;
    if (auto_rl) flag = ((t - 2) % per) == (per - 1);
    else         flag = (t - 2) >= (per - 1);
    return flag & im;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
    Din  = $urandom;
    Addr = 2'd2;
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(tag, Dout, exp);
    Addr = 2'd2;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    WE    = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  logic [31:0] exp_c[7];
  logic        exp_i[7];
  int          p;
  logic [1:0]  m;
  logic        im;
  bit          auto_rl;
  int          len;

  initial begin
    Reset = 1'b1;
    Addr  = 2'd0;
    WE    = 1'b0;
    Din   = '0;

    // Reset state: every offset reads zero, IRQ low.
    do_reset();
    rd(2'd0, "rst_ctrl", 32'd0);
    rd(2'd1, "rst_preset", 32'd0);
    rd(2'd2, "rst_count", 32'd0);
    rd(2'd3, "rst_rsvd", 32'd0);
    chk("rst_irq", IRQ, 1'b0);

    // One-shot, PRESET=3, IM set.
    exp_c = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    for (int t = 1; t <= 7; t++) begin
      tick();
      rd(2'd2, $sformatf("os_count_t%0d", t), exp_c[t-1]);
      chk($sformatf("os_irq_t%0d", t), IRQ, exp_i[t-1]);
    end
    rd(2'd0, "os_ctrl_after", 32'h8);

    // CTRL write clears the sticky flag; timer stays idle.
    wr(2'd0, 32'h8);
    chk("clr_irq", IRQ, 1'b0);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("clr_irq_hold", IRQ, 1'b0);
      rd(2'd2, "clr_count_hold", 32'd0);
    end
    wr(2'd0, 32'hFFFF_FFF8);
    rd(2'd0, "ctrl_upper_ignored", 32'h8);
    wr(2'd2, 32'd123);
    rd(2'd2, "count_ro", 32'd0);
    rd(2'd1, "preset_rb", 32'd3);

    // CTRL write on the INT edge: CPU keeps Enable, flag still sets.
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick(); tick(); tick();
    wr(2'd0, 32'hD);
    chk("race_irq", IRQ, 1'b1);
    rd(2'd0, "race_ctrl", 32'hD);
    tick();
    chk("race_irq_sticky", IRQ, 1'b1);

    // Auto-reload, PRESET=2.
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int t = 1; t <= 13; t++) begin
      tick();
      rd(2'd2, $sformatf("ar_count_t%0d", t), model_count(2, 1'b1, t));
      chk($sformatf("ar_irq_t%0d", t), IRQ, model_irq(2, 1'b1, 1'b1, t));
    end

    // PRESET write mid-count leaves COUNT alone; disable freezes COUNT.
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    tick(); tick(); tick();
    wr(2'd1, 32'd77);
    rd(2'd2, "preset_midcnt_count", 32'd8);
    rd(2'd1, "preset_midcnt_rb", 32'd77);
    tick(); tick(); tick();
    rd(2'd2, "freeze_at5", 32'd5);
    wr(2'd0, 32'h0);
    rd(2'd2, "freeze_edge", 32'd4);
    for (int t = 0; t < 3; t++) begin
      tick();
      rd(2'd2, "freeze_hold", 32'd4);
      chk("freeze_irq", IRQ, 1'b0);
    end
    rd(2'd0, "freeze_ctrl", 32'h0);

    // PRESET=0: IRQ three edges after Enable.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick();
    chk("p0_irq_t1", IRQ, 1'b0);
    tick();
    chk("p0_irq_t2", IRQ, 1'b0);
    tick();
    chk("p0_irq_t3", IRQ, 1'b1);
    rd(2'd2, "p0_count", 32'd0);

    // Enable cleared while in LOAD: load completes, then idles.
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    wr(2'd0, 32'h0);
    rd(2'd2, "ldclr_t1", 32'd0);
    for (int t = 2; t <= 4; t++) begin
      tick();
      rd(2'd2, $sformatf("ldclr_t%0d", t), 32'd4);
      chk("ldclr_irq", IRQ, 1'b0);
    end

    // Reset mid-count with a simultaneous PRESET write.
    do_reset();
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    for (int t = 1; t <= 6; t++) tick();
    rd(2'd2, "rstmid_count_pre", 32'd2);
    Reset = 1'b1;
    WE    = 1'b1;
    Addr  = 2'd1;
    Din   = 32'h55;
    tick();
    Reset = 1'b0;
    WE    = 1'b0;
    rd(2'd0, "rstmid_ctrl", 32'd0);
    rd(2'd1, "rstmid_preset", 32'd0);
    rd(2'd2, "rstmid_count", 32'd0);
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("rstmid_irq", IRQ, 1'b0);
    end

    // Randomized runs against the model.
    for (int k = 0; k < 20; k++) begin
      p       = $urandom_range(0, 6);
      m       = 2'($urandom_range(0, 3));
      im      = 1'($urandom_range(0, 1));
      auto_rl = (m == 2'b01);
      len     = 3 * (p + 2) + 3;
      do_reset();
      wr(2'd1, 32'(p));
      wr(2'd0, {28'd0, im, m, 1'b1});
      for (int t = 1; t <= len; t++) begin
        tick();
        rd(2'd2, $sformatf("rnd%0d_count_t%0d", k, t), model_count(p, auto_rl, t));
        chk($sformatf("rnd%0d_irq_t%0d", k, t), IRQ, model_irq(p, auto_rl, im, t));
      end
      rd(2'd0, $sformatf("rnd%0d_ctrl", k), {28'd0, im, m, auto_rl});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
